// File: rtl/mc_pkg.sv
// Shared constants and enums for the multi-cycle MIPS-subset core.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_e;

endpackage

// File: rtl/mc_alu.sv
// Shared combinational ALU; eq compares the raw operands for beq.
module mc_alu
    import mc_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic [31:0] o_result,
    output logic        o_eq
);

    always_comb begin
        o_result = i_a + i_b;
        case (i_op)
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_LUI: o_result = {i_b[15:0], 16'h0000};
            default: o_result = i_a + i_b;
        endcase
    end

    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core: one ALU, one req/ack memory port, FSM-sequenced datapath.
module multicycle_core
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned NREGS           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       pc_o
);

    localparam int unsigned RW = $clog2(NREGS);

    state_e      r_state, w_state_next;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [31:0] r_regs [NREGS];

    logic [5:0]    w_op, w_funct;
    logic [RW-1:0] w_rs, w_rt, w_rd, w_wb_idx;
    logic [31:0]   w_sext, w_zext, w_addr, w_addr_al;
    logic          w_is_r, w_is_imm, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_r_ok, w_legal;
    logic [31:0]   w_alu_a, w_alu_b, w_alu_y;
    alu_op_e       w_alu_op;
    logic          w_alu_eq;

    assign w_op     = r_ir[31:26];
    assign w_funct  = r_ir[5:0];
    assign w_rs     = r_ir[21 +: RW];
    assign w_rt     = r_ir[16 +: RW];
    assign w_rd     = r_ir[11 +: RW];
    assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zext   = {16'h0000, r_ir[15:0]};

    assign w_is_r   = (w_op == OP_RTYPE);
    assign w_is_imm = (w_op == OP_ADDI) || (w_op == OP_ORI) || (w_op == OP_LUI);
    assign w_is_lw  = (w_op == OP_LW);
    assign w_is_sw  = (w_op == OP_SW);
    assign w_is_beq = (w_op == OP_BEQ);
    assign w_is_j   = (w_op == OP_J);
    assign w_r_ok   = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                      (w_funct == FN_OR) || (w_funct == FN_SLT);
    assign w_legal  = (w_is_r && w_r_ok) || w_is_imm || w_is_lw || w_is_sw || w_is_beq || w_is_j;
    assign w_wb_idx = w_is_r ? w_rd : w_rt;

    // FETCH uses the ALU for PC+4, DECODE for the branch target, EXEC for the real operation.
    always_comb begin
        w_alu_a  = r_pc;
        w_alu_b  = 32'd4;
        w_alu_op = ALU_ADD;
        case (r_state)
            DECODE: w_alu_b = w_sext << 2;
            EXEC: begin
                w_alu_a = r_a;
                w_alu_b = r_b;
                if (w_is_r) begin
                    case (w_funct)
                        FN_SUB:  w_alu_op = ALU_SUB;
                        FN_AND:  w_alu_op = ALU_AND;
                        FN_OR:   w_alu_op = ALU_OR;
                        FN_SLT:  w_alu_op = ALU_SLT;
                        default: w_alu_op = ALU_ADD;
                    endcase
                end else if (w_is_beq) begin
                    w_alu_op = ALU_SUB;
                end else if (w_op == OP_ORI) begin
                    w_alu_b  = w_zext;
                    w_alu_op = ALU_OR;
                end else if (w_op == OP_LUI) begin
                    w_alu_b  = w_zext;
                    w_alu_op = ALU_LUI;
                end else begin
                    w_alu_b  = w_sext;
                end
            end
            default: ;
        endcase
    end

    mc_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_y),
        .o_eq     (w_alu_eq)
    );

    always_comb begin
        w_state_next = r_state;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        w_addr       = 32'd0;
        mem_wdata    = 32'd0;
        if (!rst) begin
            case (r_state)
                FETCH: begin
                    mem_req = 1'b1;
                    w_addr  = r_pc;
                    if (mem_ack) w_state_next = DECODE;
                end
                DECODE: begin
                    if (w_legal) begin
                        w_state_next = EXEC;
                    end else if (HALT_ON_ILLEGAL) begin
                        w_state_next = HALT;
                    end else begin
                        w_state_next = FETCH;
                        retire       = 1'b1;
                    end
                end
                EXEC: begin
                    if (w_is_beq || w_is_j) begin
                        w_state_next = FETCH;
                        retire       = 1'b1;
                    end else if (w_is_lw || w_is_sw) begin
                        w_state_next = MEM;
                    end else begin
                        w_state_next = WB;
                    end
                end
                MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = w_is_sw;
                    w_addr    = r_aluout;
                    mem_wdata = r_b;
                    if (mem_ack) begin
                        if (w_is_sw) begin
                            w_state_next = FETCH;
                            retire       = 1'b1;
                        end else begin
                            w_state_next = WB;
                        end
                    end
                end
                WB: begin
                    w_state_next = FETCH;
                    retire       = 1'b1;
                end
                HALT:    w_state_next = HALT;
                default: w_state_next = FETCH;
            endcase
        end
    end

    assign w_addr_al = w_addr & 32'hFFFF_FFFC;
    assign mem_addr  = w_addr_al[ADDR_W-1:0];
    assign halted    = (r_state == HALT) && !rst;
    assign pc_o      = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                FETCH: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata;
                        r_pc <= w_alu_y;
                    end
                end
                DECODE: begin
                    r_a      <= r_regs[w_rs];
                    r_b      <= r_regs[w_rt];
                    r_aluout <= w_alu_y;
                end
                EXEC: begin
                    if (w_is_beq) begin
                        if (w_alu_eq) r_pc <= r_aluout;
                    end else if (w_is_j) begin
                        r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    end else begin
                        r_aluout <= w_alu_y;
                    end
                end
                MEM: begin
                    if (mem_ack && !w_is_sw) r_mdr <= mem_rdata;
                end
                WB: begin
                    if (w_wb_idx != '0) r_regs[w_wb_idx] <= w_is_lw ? r_mdr : r_aluout;
                end
                default: ;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^{r_ir[25:6], w_addr_al};

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: memory writes are checked against queued expectations.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ack, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;

    logic        rst2;
    logic        req2, we2, ack2, retire2, halted2;
    logic [15:0] addr2;
    logic [31:0] wdata2, rdata2, pc2;

    always #5 clk = ~clk;

    multicycle_core #(
        .RESET_PC        (32'h0000_0100),
        .ADDR_W          (32),
        .NREGS           (32),
        .HALT_ON_ILLEGAL (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .retire    (retire),
        .halted    (halted),
        .pc_o      (pc_o)
    );

    multicycle_core #(
        .RESET_PC        (32'h0000_0000),
        .ADDR_W          (16),
        .NREGS           (8),
        .HALT_ON_ILLEGAL (1'b0)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst2),
        .mem_req   (req2),
        .mem_we    (we2),
        .mem_addr  (addr2),
        .mem_wdata (wdata2),
        .mem_rdata (rdata2),
        .mem_ack   (ack2),
        .retire    (retire2),
        .halted    (halted2),
        .pc_o      (pc2)
    );

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Main memory: variable wait states, load port used only while the core is in reset.
    logic [31:0] mem [0:255];
    logic        ld_en = 1'b0;
    logic [31:0] ld_a, ld_d;
    int          wait_n = 0;
    int          wcnt = 0;
    logic        force_ack = 1'b0;
    int          cyc = 0;
    int          cyc2 = 0;

    assign mem_ack   = (mem_req && (wcnt == wait_n)) || force_ack;
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (ld_en) mem[ld_a[9:2]] <= ld_d;
        else if (mem_req && mem_we && mem_ack) mem[mem_addr[9:2]] <= mem_wdata;
        if (!mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        cyc  <= rst ? 1 : cyc + 1;
        cyc2 <= rst2 ? 1 : cyc2 + 1;
    end

    // Second core: zero-wait ROM, last store captured.
    function automatic logic [31:0] rom2(input logic [15:0] a);
        case (a)
            16'h0000: return 32'hFC00_0000;
            16'h0004: return enc_i(6'h08, 5'd0, 5'd1, 16'd3);
            16'h0008: return enc_i(6'h2B, 5'd0, 5'd1, 16'h0040);
            16'h000C: return enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
            default:  return 32'h0000_0000;
        endcase
    endfunction

    logic [15:0] w2_a;
    logic [31:0] w2_d;
    int          w2_n = 0;
    assign ack2   = req2;
    assign rdata2 = rom2(addr2);

    always @(posedge clk) begin
        if (req2 && we2 && ack2) begin
            w2_a <= addr2;
            w2_d <= wdata2;
            w2_n <= w2_n + 1;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  ret_q[$];
    int  n_tests = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every completed store is matched against the scoreboard; retires are timestamped.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_req && mem_we && mem_ack) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_store: got addr %h data %h expected none",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.a || mem_wdata !== e.d) begin
                        n_fail++;
                        $display("FAIL store: got addr %h data %h expected addr %h data %h",
                                 mem_addr, mem_wdata, e.a, e.d);
                    end
                end
            end
            if (retire) ret_q.push_back(cyc);
        end
    end

    task automatic ld(input logic [31:0] a, input logic [31:0] d);
        ld_a  = a;
        ld_d  = d;
        ld_en = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic enter_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic release_reset();
        ret_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        force_ack = 1'b0;
    endtask

    task automatic wait_ret(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (ret_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, ret_q.size(), (ret_q.size() < n) ? n : ret_q.size());
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_retire"}, {31'd0, retire}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  k;
        logic found;
        rst  = 1'b1;
        rst2 = 1'b1;

        // Phase 1: ALU ops, $0, beq not-taken, j, beq self-loop; zero-wait memory.
        ld(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        ld(32'h104, enc_i(6'h2B, 5'd0, 5'd1, 16'h0200));
        ld(32'h108, enc_i(6'h08, 5'd0, 5'd5, 16'hFFFF));
        ld(32'h10C, enc_i(6'h08, 5'd0, 5'd6, 16'd1));
        ld(32'h110, enc_r(5'd5, 5'd6, 5'd4, 6'h2A));
        ld(32'h114, enc_i(6'h2B, 5'd0, 5'd4, 16'h0204));
        ld(32'h118, enc_r(5'd0, 5'd6, 5'd7, 6'h22));
        ld(32'h11C, enc_i(6'h2B, 5'd0, 5'd7, 16'h0208));
        ld(32'h120, enc_r(5'd1, 5'd1, 5'd0, 6'h20));
        ld(32'h124, enc_i(6'h2B, 5'd0, 5'd0, 16'h020C));
        ld(32'h128, enc_i(6'h04, 5'd1, 5'd6, 16'd1));
        ld(32'h12C, enc_i(6'h2B, 5'd0, 5'd1, 16'h0210));
        ld(32'h130, enc_r(5'd5, 5'd1, 5'd8, 6'h24));
        ld(32'h134, enc_i(6'h2B, 5'd0, 5'd8, 16'h0214));
        ld(32'h138, enc_i(6'h08, 5'd0, 5'd10, 16'h000A));
        ld(32'h13C, enc_r(5'd1, 5'd10, 5'd9, 6'h25));
        ld(32'h140, enc_i(6'h2B, 5'd0, 5'd9, 16'h0218));
        ld(32'h144, {6'h02, 26'h000_0054});
        ld(32'h148, enc_i(6'h2B, 5'd0, 5'd1, 16'h021C));
        ld(32'h14C, enc_i(6'h2B, 5'd0, 5'd1, 16'h021C));
        ld(32'h150, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
        @(negedge clk);
        chk_rst_outputs("rst_initial");

        push_wr(32'h200, 32'd5);
        push_wr(32'h204, 32'd1);
        push_wr(32'h208, 32'hFFFF_FFFF);
        push_wr(32'h20C, 32'd0);
        push_wr(32'h210, 32'd5);
        push_wr(32'h214, 32'd5);
        push_wr(32'h218, 32'h0000_000F);
        release_reset();
        @(negedge clk);
        chk("first_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("first_fetch_addr", mem_addr, 32'h100);
        wait_ret(21, 300, "p1_retire_count");
        if (ret_q.size() >= 21) begin
            chk("addi_retire_cycle", ret_q[0], 4);
            chk("sw_retire_cycle", ret_q[1], 8);
            chk("beq_nt_retire_cycle", ret_q[10], 43);
            chk("j_retire_cycle", ret_q[17], 70);
            chk("beq_loop_first", ret_q[18], 73);
            chk("beq_loop_period", ret_q[20] - ret_q[19], 3);
        end
        chk("p1_stores_pending", exp_q.size(), 0);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (mem_req) found = 1'b1;
        end
        chk("loop_fetch_addr", mem_addr, 32'h150);
        chk("loop_pc", pc_o, 32'h150);

        // Phase 2: lui/ori/sw/lw with three wait states, plus an unaligned store.
        enter_reset();
        wait_n = 3;
        ld(32'h100, enc_i(6'h0F, 5'd0, 5'd2, 16'h1234));
        ld(32'h104, enc_i(6'h0D, 5'd2, 5'd2, 16'h5678));
        ld(32'h108, enc_i(6'h2B, 5'd0, 5'd2, 16'h0008));
        ld(32'h10C, enc_i(6'h23, 5'd0, 5'd3, 16'h0008));
        ld(32'h110, enc_i(6'h2B, 5'd0, 5'd3, 16'h0220));
        ld(32'h114, enc_i(6'h2B, 5'd0, 5'd3, 16'h0227));
        ld(32'h118, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        ld(32'h008, 32'd0);
        push_wr(32'h008, 32'h1234_5678);
        push_wr(32'h220, 32'h1234_5678);
        push_wr(32'h224, 32'h1234_5678);
        release_reset();
        wait_ret(6, 400, "p2_retire_count");
        if (ret_q.size() >= 6) begin
            chk("lui_wait_cycles", ret_q[0], 7);
            chk("sw_wait_cycles", ret_q[2] - ret_q[1], 10);
            chk("lw_wait_cycles", ret_q[3] - ret_q[2], 11);
        end
        chk("mem8_value", mem[2], 32'h1234_5678);
        chk("p2_stores_pending", exp_q.size(), 0);

        // Phase 3: reset while a store waits in MEM, with a stray ack during reset.
        enter_reset();
        wait_n = 6;
        ld(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd7));
        ld(32'h104, enc_i(6'h2B, 5'd0, 5'd1, 16'h0230));
        ld(32'h230, 32'd0);
        ld(32'h234, 32'hDEAD_BEEF);
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) found = 1'b1;
        end
        chk("p3_store_seen", {31'd0, found}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        chk_rst_outputs("rst_mid_mem");
        ld(32'h100, enc_i(6'h2B, 5'd0, 5'd1, 16'h0234));
        ld(32'h104, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        push_wr(32'h234, 32'd0);
        release_reset();
        @(negedge clk);
        chk("restart_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("restart_fetch_addr", mem_addr, 32'h100);
        wait_ret(2, 200, "p3_retire_count");
        if (ret_q.size() >= 1) chk("sw_restart_cycles", ret_q[0], 16);
        chk("abandoned_store", mem[8'h8C], 32'd0);
        chk("p3_stores_pending", exp_q.size(), 0);

        // Phase 4: illegal opcode halts the core.
        enter_reset();
        wait_n = 0;
        ld(32'h100, 32'hFC00_0000);
        release_reset();
        @(negedge clk);
        @(negedge clk);
        chk("halted_before", {31'd0, halted}, 32'd0);
        @(negedge clk);
        chk("halted_after", {31'd0, halted}, 32'd1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req || retire || !halted) k++;
        end
        chk("halt_quiet", k, 0);
        chk("halt_pc", pc_o, 32'h104);

        // Phase 5: illegal opcode retires as a NOP on the second core.
        @(posedge clk);
        #1 rst2 = 1'b0;
        @(negedge clk);
        chk("nop_fetch_addr", {16'd0, addr2}, 32'h0);
        @(negedge clk);
        chk("nop_retire", {31'd0, retire2}, 32'd1);
        @(negedge clk);
        chk("nop_next_req", {31'd0, req2}, 32'd1);
        chk("nop_next_addr", {16'd0, addr2}, 32'h4);
        k = 0;
        while (w2_n < 1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("nop_store_count", w2_n, 1);
        chk("nop_store_addr", {16'd0, w2_a}, 32'h40);
        chk("nop_store_data", w2_d, 32'd3);
        chk("nop_not_halted", {31'd0, halted2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle MIPS-subset core that replaces the single-cycle datapath with one FSM-sequenced datapath sharing a single ALU and a single unified memory port. Instruction and data accesses go through one req/ack handshake port, so the core tolerates variable-latency memory. The block holds PC, IR, the register file and the holding registers (A, B, ALUOut, MDR). It exposes retire/halt status for the bench and the system top.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, default 32: width of `mem_addr`, taken from the low bits of the byte address (range 2..32).
- `NREGS`, default 32: architectural register count, power of 2 (8..32). Register indices are truncated to log2(NREGS) bits.
- `HALT_ON_ILLEGAL`, default 1:
  - 1: an unknown opcode/funct enters HALT.
  - 0: it retires as a NOP.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  access request; held high until ack is sampled.
- `mem_we`  out  1  write strobe; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W  byte address, word aligned.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  read data; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  completes the access in the same cycle.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `halted`  out  1  sticky; high in HALT.
- `pc_o`  out  32  current PC register.

## Operation
- Supported instructions:
  - R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - I-type: addi 0x08 (sign-extended), ori 0x0D (zero-extended), lui 0x0F (imm<<16), lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
- Arithmetic is modulo 2^32 with no overflow trap. Register $0 reads 0 and ignores writes.
- FSM states and transitions:
  - FETCH:
    - `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
    - On ack: IR<=rdata, PC<=PC+4, go to DECODE.
  - DECODE:
    - A<=R[rs], B<=R[rt].
    - ALUOut<=PC+(sext(imm)<<2), the branch target.
    - Illegal instruction: go to HALT if `HALT_ON_ILLEGAL`, else pulse `retire` and go to FETCH.
    - Otherwise go to EXEC.
  - EXEC, by instruction class:
    - R/ALU-imm: ALUOut<=result, go to WB.
    - lw/sw: ALUOut<=A+sext(imm), go to MEM.
    - beq: if A==B then PC<=ALUOut. Retire, go to FETCH.
    - j: PC<={PC[31:28],imm26,2'b00}. Retire, go to FETCH.
  - MEM:
    - `mem_req`=1, `mem_addr`=ALUOut, `mem_we`=sw, `mem_wdata`=B.
    - On ack, lw: MDR<=rdata, go to WB.
    - On ack, sw: retire, go to FETCH.
  - WB: write R[rd] (R-type) or R[rt] (I-type), from MDR for lw or ALUOut otherwise. Retire, go to FETCH.
  - HALT: stays in HALT until `rst`. No memory requests are issued.
- Address bits [1:0] are ignored. An unaligned lw/sw is performed at the aligned word.

## Timing
- While `rst` is high: state<=FETCH, PC<=RESET_PC, all registers and IR/A/B/MDR/ALUOut cleared.
- Output values while `rst` is high: `mem_req`=0, `mem_we`=0, `retire`=0, `halted`=0, `mem_addr`=0, `mem_wdata`=0.
- First cycle after `rst` falls: `mem_req`=1, `mem_addr`=RESET_PC.
- Memory handshake:
  - `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are decoded from registered state and stay stable while waiting for ack.
  - Ack may arrive in the first request cycle, giving zero wait states.
  - `mem_ack` while `mem_req`=0 is ignored.
- Cycle counts with zero-wait memory: beq/j 3, R/ALU-imm/sw 4, lw 5. Each wait state adds 1 cycle to FETCH or MEM.
- `retire` is asserted in the last cycle of the instruction. `halted` rises the cycle after DECODE detects the illegal instruction.
- `rst` has priority over every state, including mid-handshake. An outstanding access is abandoned and a late ack is ignored.

## Structure
- Package `mc_pkg` holds:
  - opcode and funct constants;
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - the ALU-op enum (ADD, SUB, AND, OR, SLT, LUI).
- Sub-module `mc_alu`: combinational; 32-bit operands, ALU-op input; outputs result and `eq`.
- The register file, FSM and holding registers live in `multicycle_core`.

## Test plan
- Reset with `RESET_PC`=0x100 and zero-wait memory → first `mem_addr`=0x100. `addi $1,$0,5` retires at cycle 4 and R1=5.
- `lui $2,0x1234`; `ori $2,$2,0x5678`; `sw $2,8($0)`; `lw $3,8($0)` with 3 wait states on every access → mem[8]=0x12345678, R3=0x12345678, lw takes 11 cycles.
- `beq $1,$1,-1` → PC returns to the same instruction and the branch repeats every 3 cycles. `beq` with unequal operands → falls through to PC+4.
- `add $0,$1,$1` → R0 still reads 0. `slt $4,$5,$6` with R5=0xFFFFFFFF, R6=1 → R4=1. `sub` with 0−1 → 0xFFFFFFFF.
- Opcode 0x3F with `HALT_ON_ILLEGAL`=1 → `halted`=1 and `mem_req` stays 0. With `HALT_ON_ILLEGAL`=0 → `retire` pulses and the next fetch is at PC+4.
- `rst` asserted during a MEM wait, then ack arrives after `rst` falls → no register/memory side effects, and the fetch restarts at `RESET_PC`.
